// File: rtl/pcw_mouse_if.sv
// pcw_mouse_if: decodes toggle-strobed PS/2 mouse packets into PCW Kempston counters or AMX quadrature lines.
// Latency: an accepted packet updates counters/pending motion and pulses pkt_seen one cycle later; AMX moves one phase step per STEP_DIV cycles.
// Backpressure: none; packets must be at least 2 cycles apart and nothing is queued.
// Ports: clk_sys/reset_n; ps2_mouse packet bus ({strobe, Y, X, flags}); mouse_type mode select;
//        io_sel/io_dout register read port; amx_x/amx_y/amx_btn_n AMX lines; pkt_seen accept pulse.
module pcw_mouse_if #(
    parameter int STEP_DIV = 6400,
    parameter int PEND_W   = 10     // must be at least 9 to hold one full packet delta
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic [1:0]  mouse_type,
    input  logic [1:0]  io_sel,
    output logic [7:0]  io_dout,
    output logic [1:0]  amx_x,
    output logic [1:0]  amx_y,
    output logic [2:0]  amx_btn_n,
    output logic        pkt_seen
);

    localparam int TW = $clog2(STEP_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(STEP_DIV - 1);
    // Two guard bits so pend + delta - 1 never overflows before clamping.
    localparam int SW = PEND_W + 2;
    localparam logic signed [SW-1:0] P_MAX = SW'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [SW-1:0] P_MIN = ~P_MAX;

    typedef enum logic [1:0] {
        MT_NONE = 2'd0,
        MT_AMX  = 2'd1,
        MT_KEMP = 2'd2,
        MT_KEY  = 2'd3
    } mtype_t;

    logic                     strb_q;
    logic                     arm;
    mtype_t                   type_q;
    logic [7:0]               x_cnt;
    logic [7:0]               y_cnt;
    logic [2:0]               btn_n;
    logic signed [PEND_W-1:0] pend_x;
    logic signed [PEND_W-1:0] pend_y;
    logic [1:0]               ph_x;
    logic [1:0]               ph_y;
    logic [TW-1:0]            tmr;

    logic [7:0]      flags;
    logic            mode_chg;
    logic            accept;
    logic            tick;
    logic signed [8:0] dx;
    logic signed [8:0] dy;

    always_comb begin
        flags    = ps2_mouse[7:0];
        mode_chg = (mtype_t'(mouse_type) != type_q);
        // A packet colliding with a mode switch is dropped along with the old state.
        accept   = arm && (ps2_mouse[24] != strb_q) && !mode_chg;
        tick     = (type_q == MT_AMX) && !mode_chg && (tmr == T_LAST);
        dx       = flags[6] ? '0 : {flags[4], ps2_mouse[15:8]};
        dy       = flags[7] ? '0 : {flags[5], ps2_mouse[23:16]};
    end

    // Saturating update; the tick's move toward zero uses the sign before the add.
    function automatic logic signed [PEND_W-1:0] pend_upd(
        input logic signed [PEND_W-1:0] p,
        input logic signed [8:0]        d,
        input logic                     acc,
        input logic                     tk
    );
        logic signed [SW-1:0] s;
        s = {{2{p[PEND_W-1]}}, p};
        if (acc)
            s = s + {{(SW-9){d[8]}}, d};
        if (tk && (p != '0))
            s = p[PEND_W-1] ? s + SW'(1) : s - SW'(1);
        if (s > P_MAX)
            s = P_MAX;
        else if (s < P_MIN)
            s = P_MIN;
        return s[PEND_W-1:0];
    endfunction

    // Gray walk 00->01->11->10 for positive motion, reverse for negative.
    function automatic logic [1:0] ph_next(
        input logic [1:0]               p,
        input logic signed [PEND_W-1:0] pend
    );
        if (pend == '0)
            return p;
        else if (pend[PEND_W-1])
            return {~p[0], p[1]};
        else
            return {p[0], ~p[1]};
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strb_q   <= 1'b0;
            arm      <= 1'b0;
            type_q   <= MT_NONE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            btn_n    <= 3'b111;
            pend_x   <= '0;
            pend_y   <= '0;
            ph_x     <= 2'b00;
            ph_y     <= 2'b00;
            tmr      <= '0;
            pkt_seen <= 1'b0;
        end else begin
            // First cycle after reset only samples the strobe level (arm is still 0).
            strb_q   <= ps2_mouse[24];
            arm      <= 1'b1;
            type_q   <= mtype_t'(mouse_type);
            pkt_seen <= accept;
            if (accept)
                btn_n <= ~flags[2:0];

            if (mode_chg || (type_q == MT_NONE) || (type_q == MT_KEY)) begin
                x_cnt  <= '0;
                y_cnt  <= '0;
                pend_x <= '0;
                pend_y <= '0;
                ph_x   <= 2'b00;
                ph_y   <= 2'b00;
                tmr    <= '0;
            end else if (type_q == MT_KEMP) begin
                if (accept) begin
                    x_cnt <= x_cnt + dx[7:0];
                    y_cnt <= y_cnt + dy[7:0];
                end
            end else begin
                tmr    <= tick ? '0 : tmr + 1'b1;
                pend_x <= pend_upd(pend_x, dx, accept, tick);
                pend_y <= pend_upd(pend_y, dy, accept, tick);
                if (tick) begin
                    ph_x <= ph_next(ph_x, pend_x);
                    ph_y <= ph_next(ph_y, pend_y);
                end
            end
        end
    end

    always_comb begin
        io_dout = 8'hFF;
        if (type_q == MT_KEMP) begin
            case (io_sel)
                2'd0:    io_dout = x_cnt;
                2'd1:    io_dout = y_cnt;
                2'd2:    io_dout = {5'b11111, btn_n};
                default: io_dout = 8'hFF;
            endcase
        end
    end

    assign amx_x     = ph_x;
    assign amx_y     = ph_y;
    assign amx_btn_n = (type_q == MT_AMX) ? btn_n : 3'b111;

endmodule

// File: tb/tb_pcw_mouse_if.sv
// tb_pcw_mouse_if: directed plus random stimulus for pcw_mouse_if against an integer reference model.
// Latency: model advances one clk_sys edge per step(); outputs are compared 1 time unit after each edge.
// Backpressure: none; the driver keeps packets at least 2 cycles apart.
module tb_pcw_mouse_if;

    localparam int STEP_DIV = 4;
    localparam int PEND_W   = 10;
    localparam int PMAX     = (1 << (PEND_W - 1)) - 1;
    localparam int PMIN     = -(1 << (PEND_W - 1));

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [24:0] ps2_mouse;
    logic [1:0]  mouse_type;
    logic [1:0]  io_sel;
    logic [7:0]  io_dout;
    logic [1:0]  amx_x;
    logic [1:0]  amx_y;
    logic [2:0]  amx_btn_n;
    logic        pkt_seen;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: counters as plain integers, AMX phase as a position 0..3.
    bit         m_arm, m_strb, m_pkt;
    int         m_type_q, m_x, m_y, m_px, m_py, m_posx, m_posy, m_timer;
    logic [2:0] m_btn;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    pcw_mouse_if #(.STEP_DIV(STEP_DIV), .PEND_W(PEND_W)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_mouse  (ps2_mouse),
        .mouse_type (mouse_type),
        .io_sel     (io_sel),
        .io_dout    (io_dout),
        .amx_x      (amx_x),
        .amx_y      (amx_y),
        .amx_btn_n  (amx_btn_n),
        .pkt_seen   (pkt_seen)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int decode(input logic [7:0] mag, input logic neg, input logic ovf);
        int v;
        v = int'(mag);
        if (neg) v -= 256;
        if (ovf) v = 0;
        return v;
    endfunction

    function automatic logic [7:0] exp_dout();
        if (m_type_q != 2) return 8'hFF;
        case (io_sel)
            2'd0:    return 8'(m_x);
            2'd1:    return 8'(m_y);
            2'd2:    return {5'b11111, m_btn};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_arm = 0; m_strb = 0; m_pkt = 0; m_type_q = 0;
        m_x = 0; m_y = 0; m_px = 0; m_py = 0;
        m_posx = 0; m_posy = 0; m_timer = 0; m_btn = 3'b111;
    endtask

    task automatic check_all();
        chk("pkt_seen", 32'(pkt_seen), 32'(m_pkt));
        chk("amx_x", 32'(amx_x), 32'(gray[m_posx]));
        chk("amx_y", 32'(amx_y), 32'(gray[m_posy]));
        chk("amx_btn_n", 32'(amx_btn_n), 32'((m_type_q == 1) ? m_btn : 3'b111));
        chk("io_dout", 32'(io_dout), 32'(exp_dout()));
    endtask

    // One clock: evaluate the model on the inputs presented, clock, then compare.
    task automatic step();
        bit chg, acc, tick;
        int dx, dy, n_x, n_y, n_px, n_py, n_posx, n_posy, n_timer;
        logic [2:0] n_btn;
        chg  = (int'(mouse_type) != m_type_q);
        acc  = m_arm && (ps2_mouse[24] != m_strb) && !chg;
        dx   = decode(ps2_mouse[15:8], ps2_mouse[4], ps2_mouse[6]);
        dy   = decode(ps2_mouse[23:16], ps2_mouse[5], ps2_mouse[7]);
        tick = (m_type_q == 1) && !chg && (m_timer == STEP_DIV - 1);
        n_x = m_x; n_y = m_y; n_px = m_px; n_py = m_py;
        n_posx = m_posx; n_posy = m_posy; n_timer = m_timer;
        n_btn = acc ? ~ps2_mouse[2:0] : m_btn;
        if (chg || m_type_q == 0 || m_type_q == 3) begin
            n_x = 0; n_y = 0; n_px = 0; n_py = 0; n_posx = 0; n_posy = 0; n_timer = 0;
        end else if (m_type_q == 2) begin
            if (acc) begin
                n_x = (m_x + dx) & 255;
                n_y = (m_y + dy) & 255;
            end
        end else begin
            n_timer = (m_timer + 1) % STEP_DIV;
            n_px = clamp(m_px + (acc ? dx : 0) - (tick ? sgn(m_px) : 0));
            n_py = clamp(m_py + (acc ? dy : 0) - (tick ? sgn(m_py) : 0));
            if (tick) begin
                n_posx = (m_posx + 4 + sgn(m_px)) % 4;
                n_posy = (m_posy + 4 + sgn(m_py)) % 4;
            end
        end
        @(posedge clk_sys);
        m_arm = 1; m_strb = ps2_mouse[24]; m_type_q = int'(mouse_type); m_pkt = acc;
        m_btn = n_btn; m_x = n_x; m_y = n_y; m_px = n_px; m_py = n_py;
        m_posx = n_posx; m_posy = n_posy; m_timer = n_timer;
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f);
        ps2_mouse = {~ps2_mouse[24], y, x, f};
        step();
        step();
    endtask

    task automatic run_count(input int ncyc, output int changes);
        logic [1:0] prev;
        prev = amx_x;
        changes = 0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            if (amx_x != prev) changes++;
            prev = amx_x;
        end
    endtask

    initial begin
        int         nch, last, bad;
        logic [1:0] prev;

        reset_n = 1'b0; ps2_mouse = {1'b1, 24'h0}; mouse_type = 2'd2; io_sel = 2'd0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_pkt", 32'(pkt_seen), 32'd0);
        chk("rst_amx_x", 32'(amx_x), 32'd0);
        chk("rst_btn", 32'(amx_btn_n), 32'h7);
        chk("rst_dout", 32'(io_dout), 32'hFF);

        // 1: stale strobe level is not a packet; first real toggle is.
        reset_n = 1'b1;
        step();
        chk("t1_nopkt", 32'(pkt_seen), 32'd0);
        step();
        chk("t1_x0", 32'(io_dout), 32'h00);
        ps2_mouse = {1'b0, 8'h00, 8'h05, 8'h00};
        step();
        chk("t1_pkt", 32'(pkt_seen), 32'd1);
        step();
        chk("t1_x5", 32'(io_dout), 32'h05);

        // 2: Kempston wrap, negative Y, overflow flag.
        send(8'hF9, 8'h00, 8'h00);
        send(8'h03, 8'h00, 8'h00);
        chk("t2_xwrap", 32'(io_dout), 32'h01);
        io_sel = 2'd1;
        send(8'h00, 8'hFF, 8'h20);
        chk("t2_yneg", 32'(io_dout), 32'hFF);
        io_sel = 2'd0;
        send(8'h40, 8'h00, 8'h40);
        chk("t2_xovf", 32'(io_dout), 32'h01);

        // 3: buttons and reserved select.
        send(8'h00, 8'h00, 8'h05);
        io_sel = 2'd2; #1;
        chk("t3_btn", 32'(io_dout), 32'hFA);
        io_sel = 2'd3; #1;
        chk("t3_rsvd", 32'(io_dout), 32'hFF);

        for (int i = 0; i < 30; i++) begin
            io_sel = 2'($urandom_range(0, 3));
            send(8'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end

        // 4: AMX step sequence and spacing.
        mouse_type = 2'd1;
        step(); step();
        ps2_mouse = {~ps2_mouse[24], 8'h00, 8'h03, 8'h00};
        prev = amx_x; nch = 0; last = -1; bad = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (amx_x != prev) begin
                if (last >= 0 && (c - last) != STEP_DIV) bad++;
                last = c; nch++;
            end
            prev = amx_x;
        end
        chk("t4_pos_steps", 32'(nch), 32'd3);
        chk("t4_spacing", 32'(bad), 32'd0);
        chk("t4_pos_final", 32'(amx_x), 32'(2'b10));
        ps2_mouse = {~ps2_mouse[24], 8'h00, 8'hFE, 8'h10};
        run_count(30, nch);
        chk("t4_neg_steps", 32'(nch), 32'd2);
        chk("t4_neg_final", 32'(amx_x), 32'(2'b01));

        // 5: saturation, then accept coinciding with a tick.
        for (int g = 0; g < STEP_DIV && m_timer != 0; g++) step();
        repeat (4) send(8'hFF, 8'h00, 8'h00);
        run_count(2200, nch);
        chk("t5_sat_steps", 32'(nch), 32'd510);
        for (int g = 0; g < STEP_DIV && m_timer != 0; g++) step();
        send(8'h05, 8'h00, 8'h00);
        step();
        send(8'h02, 8'h00, 8'h00);
        run_count(40, nch);
        chk("t5_tick_acc", 32'(nch), 32'd6);

        // 6: mode switch clears AMX state and drops a colliding packet.
        send(8'h14, 8'h00, 8'h00);
        repeat (8) step();
        mouse_type = 2'd2; io_sel = 2'd0;
        ps2_mouse = {~ps2_mouse[24], 8'h00, 8'h33, 8'h00};
        step();
        chk("t6_nopkt", 32'(pkt_seen), 32'd0);
        chk("t6_amx0", 32'(amx_x), 32'd0);
        chk("t6_x0", 32'(io_dout), 32'h00);
        repeat (12) step();
        chk("t6_dropped", 32'(io_dout), 32'h00);

        // Random AMX traffic on both axes, then drain.
        mouse_type = 2'd1;
        step();
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 6)) step();
        end
        for (int g = 0; g < 6000 && (m_px != 0 || m_py != 0); g++) step();
        n_chk++;
        if (m_px != 0 || m_py != 0) begin
            n_err++;
            $display("FAIL amx_drain timeout observed pend=%0d/%0d required=0/0", m_px, m_py);
        end

        // Asynchronous reset mid-motion, then resynchronise.
        send(8'h80, 8'h00, 8'h00);
        repeat (5) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_amx_x", 32'(amx_x), 32'd0);
        chk("mrst_btn", 32'(amx_btn_n), 32'h7);
        chk("mrst_pkt", 32'(pkt_seen), 32'd0);
        chk("mrst_dout", 32'(io_dout), 32'hFF);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1; mouse_type = 2'd2; io_sel = 2'd0;
        step(); step();
        chk("mrst_x0", 32'(io_dout), 32'h00);
        send(8'h07, 8'h00, 8'h00);
        chk("mrst_x7", 32'(io_dout), 32'h07);

        // None mode: buttons still captured, reads stay 0xFF.
        mouse_type = 2'd0;
        step(); step();
        send(8'h11, 8'h22, 8'h02);
        chk("none_dout", 32'(io_dout), 32'hFF);
        mouse_type = 2'd2;
        step(); step();
        io_sel = 2'd2; #1;
        chk("none_btn", 32'(io_dout), 32'hFD);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
